mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Arbitrates a single shared main-memory port between two miss requesters.
  - Port 0: instruction-side refill.
  - Port 1: data-side L2 refill or write-through.
- Sequences each transaction:
  - fixed-latency wait;
  - then either a BURST_LEN-word line read or a single-word write.
- Sits between the cache hierarchy and data memory, replacing the direct L2-to-memory hookup.
- Its `word_idx` output serves as the refill word counter consumed by the caches.

Parameters:
- AW, 32, address width in bits (byte address).
- DW, 32, data word width.
- BURST_LEN, 8, words per line read; power of two, at least 2.
- MEM_LAT, 4, wait cycles before the first data word; at least 1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req0  in  1  port 0 request; level, held until done0.
- addr0  in  AW  port 0 byte address.
- we0  in  1  port 0 write (1) / line read (0).
- wdata0  in  DW  port 0 write data.
- req1, addr1, we1, wdata1  in  1/AW/1/DW  port 1, same meaning.
- gnt0  out  1  port 0 owns memory.
- gnt1  out  1  port 1 owns memory.
- done0  out  1  one-cycle completion pulse, port 0.
- done1  out  1  one-cycle completion pulse, port 1.
- rvalid  out  1  rdata valid this cycle (read XFER only).
- rdata  out  DW  read word, combinational pass of mem_rdata.
- word_idx  out  $clog2(BURST_LEN)  index of the current burst word.
- mem_addr  out  AW  memory address, registered.
- mem_we  out  1  memory write strobe.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, combinational from mem_addr.

Behaviour:
- FSM states: IDLE, WAIT, XFER, DONE. Exactly one grant is active outside IDLE.
- Reset (rst=0, async, also mid-transaction):
  - state=IDLE; all outputs 0; lat_cnt=0; word_idx=0.
  - last-served pointer=1, so port 0 wins the first tie.
  - Any in-flight transaction is aborted with no done pulse.
- IDLE, only one req high: grant that port.
- IDLE, both req high: grant the port not equal to the last-served pointer.
- IDLE grant edge actions:
  - Latch we and wdata.
  - Read: mem_addr = addr with low $clog2(BURST_LEN)+2 bits cleared (line aligned).
  - Write: mem_addr = addr exactly.
  - lat_cnt = MEM_LAT-1; go to WAIT.
- Grant timing: req sampled at edge N gives gnt at cycle N+1. gnt stays high through DONE inclusive.
- WAIT:
  - Decrement lat_cnt each cycle.
  - When lat_cnt==0: go to XFER, word_idx=0.
  - WAIT lasts exactly MEM_LAT cycles.
- XFER, read:
  - rvalid=1 every cycle; rdata=mem_rdata.
  - Each edge: mem_addr += 4, word_idx += 1.
  - After word BURST_LEN-1, go to DONE.
  - Lasts exactly BURST_LEN cycles; word_idx runs 0..BURST_LEN-1 with no wrap beyond the burst.
- XFER, write:
  - mem_we=1 and mem_wdata=latched wdata for exactly one cycle; rvalid stays 0.
  - Go to DONE.
- DONE:
  - done<granted>=1 for one cycle; rvalid=0, mem_we=0.
  - Update last-served pointer to the granted port.
  - Next state IDLE; gnt drops on the same edge.
- The requester must deassert req in the DONE cycle. A req still high in IDLE is treated as a new request.
- Request drop or address change after the grant edge is ignored; the transaction completes with the latched values.
- Requests are never accepted outside IDLE; the losing requester simply waits.
- Back-to-back traffic: minimum one IDLE cycle between transactions.
- Total read transaction length: 1 + MEM_LAT + BURST_LEN + 1 cycles from request sample to IDLE.
- Address arithmetic wraps modulo 2^AW.

Optional Feature:
- Macro: ARB_FIXED_PRIO_EN.
- Defined: port 1 (data side) always wins a simultaneous request. The last-served pointer is still maintained but unused for the decision.
- Undefined: round-robin as described in Behaviour.

Test Plan:
- Reset, then req0=1, we0=0, addr0=0x104 at edge 0:
  - gnt0 high at cycle 1; rvalid high cycles 5..12;
  - mem_addr 0x100..0x11C; word_idx 0..7; done0 at cycle 13.
- req1=1, we1=1, addr1=0x208, wdata1=0xDEADBEEF:
  - exactly one mem_we pulse with mem_addr=0x208, mem_wdata=0xDEADBEEF;
  - done1 on the following cycle; rvalid never high.
- req0 and req1 both high from reset, held high until each done:
  - grants port 0, then port 1, then port 0 (alternating);
  - with ARB_FIXED_PRIO_EN, always port 1 while req1 is held.
- req1 asserted during a port 0 WAIT:
  - gnt1 stays low until port 0 DONE;
  - port 1 is granted after the IDLE cycle.
- rst pulled low during XFER at word_idx=3:
  - all outputs 0 immediately (asynchronous);
  - no done pulse; after release, req0 tie behaviour matches the reset pointer.
- req0 dropped during WAIT:
  - the burst still completes all 8 words and done0 pulses.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one main-memory port between two miss requesters.
//   Port 0 is the instruction-side refill, port 1 the data-side refill or
//   write-through. Each granted transaction waits MEM_LAT cycles, then does a
//   BURST_LEN-word line read or a single-word write, then pulses done.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   reqN/addrN/weN/wdataN     requester N (level request, held until doneN)
//   gnt0, gnt1                port owns memory (WAIT through DONE)
//   done0, done1              one-cycle completion pulse
//   rvalid, rdata, word_idx   read beat valid, read word, burst word counter
//   mem_addr/mem_we/mem_wdata memory request side (registered)
//   mem_rdata                 memory read data, combinational from mem_addr
//
// Build option: define ARB_FIXED_PRIO_EN to make port 1 win every
// simultaneous request; otherwise ties alternate (round-robin).
module mem_arbiter #(
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned BURST_LEN = 8,
  parameter int unsigned MEM_LAT   = 4,
  localparam int unsigned IW       = $clog2(BURST_LEN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic [AW-1:0] addr0,
  input  logic          we0,
  input  logic [DW-1:0] wdata0,
  input  logic          req1,
  input  logic [AW-1:0] addr1,
  input  logic          we1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          done0,
  output logic          done1,
  output logic          rvalid,
  output logic [DW-1:0] rdata,
  output logic [IW-1:0] word_idx,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  // Line alignment clears the word-in-line bits plus the byte-in-word bits.
  localparam int unsigned AB = IW + 2;
  localparam int unsigned LW = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {StIdle, StWait, StXfer, StDone} state_e;

  state_e          state_q;
  logic [LW-1:0]   lat_cnt_q;
  logic            last_q;    // port served most recently
  logic            we_q;
  logic [DW-1:0]   wdata_q;

  logic            pick1;
  logic [AW-1:0]   addr_sel;
  logic            we_sel;
  logic [DW-1:0]   wdata_sel;

  assign rdata = mem_rdata;

  always_comb begin
    pick1 = 1'b0;
    if (req0 && req1) begin
`ifdef ARB_FIXED_PRIO_EN
      pick1 = 1'b1;
`else
      pick1 = ~last_q;
`endif
    end else begin
      pick1 = req1;
    end
  end

  assign addr_sel  = pick1 ? addr1  : addr0;
  assign we_sel    = pick1 ? we1    : we0;
  assign wdata_sel = pick1 ? wdata1 : wdata0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      lat_cnt_q <= '0;
      last_q    <= 1'b1;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      rvalid    <= 1'b0;
      word_idx  <= '0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req0 || req1) begin
            gnt0      <= ~pick1;
            gnt1      <= pick1;
            we_q      <= we_sel;
            wdata_q   <= wdata_sel;
            mem_addr  <= we_sel ? addr_sel : {addr_sel[AW-1:AB], {AB{1'b0}}};
            lat_cnt_q <= LW'(MEM_LAT - 1);
            state_q   <= StWait;
          end
        end
        StWait: begin
          if (lat_cnt_q == '0) begin
            state_q  <= StXfer;
            word_idx <= '0;
            if (we_q) begin
              mem_we    <= 1'b1;
              mem_wdata <= wdata_q;
            end else begin
              rvalid <= 1'b1;
            end
          end else begin
            lat_cnt_q <= lat_cnt_q - LW'(1);
          end
        end
        StXfer: begin
          // A write is a single beat; a read ends on the last burst word
          // with the address and index left on that word.
          if (we_q || (word_idx == IW'(BURST_LEN - 1))) begin
            state_q   <= StDone;
            rvalid    <= 1'b0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            done0     <= gnt0;
            done1     <= gnt1;
          end else begin
            mem_addr <= mem_addr + AW'(4);
            word_idx <= word_idx + IW'(1);
          end
        end
        StDone: begin
          gnt0    <= 1'b0;
          gnt1    <= 1'b0;
          last_q  <= gnt1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
